// File: rtl/v_issue_queue.sv
// In-order vector issue queue: FIFO of decoded instructions, register-group scoreboard,
// and per-unit busy tracking with done-based retirement.
module v_issue_queue #(
  parameter int QDEPTH    = 4,
  parameter int NUM_UNITS = 4,
  parameter int UNIT_W    = $clog2(NUM_UNITS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_instr,
  input  logic [UNIT_W-1:0]           in_unit,
  input  logic [4:0]                  in_vd,
  input  logic [4:0]                  in_vs1,
  input  logic [4:0]                  in_vs2,
  input  logic                        in_wr_vd,
  input  logic                        in_rd_vs1,
  input  logic                        in_rd_vs2,
  input  logic [2:0]                  in_lmul,
  input  logic                        flush,
  input  logic [NUM_UNITS-1:0]        unit_done,
  output logic [NUM_UNITS-1:0]        iss_valid,
  output logic [31:0]                 iss_instr,
  output logic [4:0]                  iss_vd,
  output logic [4:0]                  iss_vs1,
  output logic [4:0]                  iss_vs2,
  output logic [NUM_UNITS-1:0]        unit_busy,
  output logic [$clog2(QDEPTH):0]     q_count,
  output logic                        stall_hazard,
  output logic                        stall_busy,
  output logic                        idle
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  // Registers base..base+span-1, with indices past 31 simply falling off the top.
  function automatic logic [31:0] group_mask(input logic [4:0] base, input logic [3:0] span);
    logic [31:0] m;
    logic [5:0]  lim;
    logic [5:0]  idx;
    lim = {1'b0, base} + {2'b00, span};
    for (int i = 0; i < 32; i++) begin
      idx  = 6'(i);
      m[i] = (idx >= {1'b0, base}) && (idx < lim);
    end
    return m;
  endfunction

  logic [31:0]       q_instr [QDEPTH];
  logic [UNIT_W-1:0] q_unit  [QDEPTH];
  logic [4:0]        q_vd    [QDEPTH];
  logic [4:0]        q_vs1   [QDEPTH];
  logic [4:0]        q_vs2   [QDEPTH];
  logic              q_wr    [QDEPTH];
  logic              q_rd1   [QDEPTH];
  logic              q_rd2   [QDEPTH];
  logic [3:0]        q_span  [QDEPTH];

  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [31:0]       pending;
  logic [31:0]       unit_mask [NUM_UNITS];
  logic [31:0]       last_instr;
  logic [4:0]        last_vd, last_vs1, last_vs2;

  logic              empty, full, push, issue, hazard, head_busy;
  logic [3:0]        in_span;
  logic [31:0]       head_vd_mask, clr_mask;
  logic [NUM_UNITS-1:0] done_eff;

  assign empty    = (count == '0);
  assign full     = (count == CW'(QDEPTH));
  assign in_ready = !full;
  assign push     = in_valid && !full && !flush;
  assign in_span  = in_lmul[2] ? 4'd1 : (4'd1 << in_lmul[1:0]);

  assign head_vd_mask = group_mask(q_vd[rd_ptr], q_span[rd_ptr]);
  assign hazard = !empty && (
      (q_rd1[rd_ptr] && |(pending & group_mask(q_vs1[rd_ptr], q_span[rd_ptr]))) ||
      (q_rd2[rd_ptr] && |(pending & group_mask(q_vs2[rd_ptr], q_span[rd_ptr]))) ||
      (q_wr[rd_ptr]  && |(pending & head_vd_mask)));
  assign head_busy = unit_busy[q_unit[rd_ptr]];
  assign issue     = !empty && !hazard && !head_busy && !flush;

  assign stall_hazard = !empty && hazard;
  assign stall_busy   = !empty && !hazard && head_busy;
  assign idle         = empty && (unit_busy == '0);
  assign q_count      = count;

  assign iss_valid = issue ? (NUM_UNITS'(1) << q_unit[rd_ptr]) : '0;
  assign iss_instr = issue ? q_instr[rd_ptr] : last_instr;
  assign iss_vd    = issue ? q_vd[rd_ptr]    : last_vd;
  assign iss_vs1   = issue ? q_vs1[rd_ptr]   : last_vs1;
  assign iss_vs2   = issue ? q_vs2[rd_ptr]   : last_vs2;

  // Done pulses only count for units actually in flight; their recorded groups get released.
  always_comb begin
    done_eff = unit_done & unit_busy;
    clr_mask = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (done_eff[u]) clr_mask = clr_mask | unit_mask[u];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= in_instr;
      q_unit[wr_ptr]  <= in_unit;
      q_vd[wr_ptr]    <= in_vd;
      q_vs1[wr_ptr]   <= in_vs1;
      q_vs2[wr_ptr]   <= in_vs2;
      q_wr[wr_ptr]    <= in_wr_vd;
      q_rd1[wr_ptr]   <= in_rd_vs1;
      q_rd2[wr_ptr]   <= in_rd_vs2;
      q_span[wr_ptr]  <= in_span;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pending    <= '0;
      unit_busy  <= '0;
      last_instr <= '0;
      last_vd    <= '0;
      last_vs1   <= '0;
      last_vs2   <= '0;
      for (int u = 0; u < NUM_UNITS; u++) unit_mask[u] <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (issue) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(issue);
      end
      // Clear and set cannot collide: the WAW check keeps in-flight groups disjoint.
      pending   <= (pending & ~clr_mask) | ((issue && q_wr[rd_ptr]) ? head_vd_mask : 32'd0);
      unit_busy <= (unit_busy & ~done_eff) | iss_valid;
      if (issue) begin
        unit_mask[q_unit[rd_ptr]] <= q_wr[rd_ptr] ? head_vd_mask : 32'd0;
        last_instr <= q_instr[rd_ptr];
        last_vd    <= q_vd[rd_ptr];
        last_vs1   <= q_vs1[rd_ptr];
        last_vs2   <= q_vs2[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_v_issue_queue.sv
// Randomized and directed bench for v_issue_queue, checked cycle by cycle against
// a queue-based model of the issue rules.
module tb_v_issue_queue;

  localparam int QDEPTH    = 4;
  localparam int NUM_UNITS = 4;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_instr = 0;
  logic [1:0]  in_unit = 0;
  logic [4:0]  in_vd = 0, in_vs1 = 0, in_vs2 = 0;
  logic        in_wr_vd = 0, in_rd_vs1 = 0, in_rd_vs2 = 0;
  logic [2:0]  in_lmul = 0;
  logic        flush = 0;
  logic [3:0]  unit_done = 0;
  logic [3:0]  iss_valid;
  logic [31:0] iss_instr;
  logic [4:0]  iss_vd, iss_vs1, iss_vs2;
  logic [3:0]  unit_busy;
  logic [2:0]  q_count;
  logic        stall_hazard, stall_busy, idle;

  v_issue_queue #(.QDEPTH(QDEPTH), .NUM_UNITS(NUM_UNITS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_unit(in_unit),
    .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
    .in_wr_vd(in_wr_vd), .in_rd_vs1(in_rd_vs1), .in_rd_vs2(in_rd_vs2), .in_lmul(in_lmul),
    .flush(flush), .unit_done(unit_done),
    .iss_valid(iss_valid), .iss_instr(iss_instr), .iss_vd(iss_vd), .iss_vs1(iss_vs1),
    .iss_vs2(iss_vs2), .unit_busy(unit_busy), .q_count(q_count),
    .stall_hazard(stall_hazard), .stall_busy(stall_busy), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int unit, vd, vs1, vs2, span;
    bit wr, r1, r2;
  } entry_t;

  entry_t modelQ[$];
  bit     pend[32];
  bit     busy[NUM_UNITS];
  bit     recWr[NUM_UNITS];
  int     recBase[NUM_UNITS];
  int     recSpan[NUM_UNITS];
  logic [31:0] heldInstr;
  int     heldVd, heldVs1, heldVs2;
  int     errors = 0;
  int     checks = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit groupPending(int base, int span);
    for (int r = base; r < base + span && r < 32; r++) if (pend[r]) return 1;
    return 0;
  endfunction

  function automatic void modelReset();
    modelQ.delete();
    foreach (pend[r]) pend[r] = 0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      busy[u] = 0; recWr[u] = 0; recBase[u] = 0; recSpan[u] = 0;
    end
    heldInstr = 0; heldVd = 0; heldVs1 = 0; heldVs2 = 0;
  endfunction

  task automatic applyStimulus(input bit v, input logic [31:0] instr, input int unit,
                               input int vd, input int vs1, input int vs2,
                               input bit wr, input bit r1, input bit r2, input int lmul,
                               input bit fl, input logic [3:0] done);
    entry_t h, e;
    bit nonEmpty, hz, hBusy, doIssue;
    logic [3:0] expBusy;
    @(negedge clk);
    in_valid = v; in_instr = instr; in_unit = 2'(unit);
    in_vd = 5'(vd); in_vs1 = 5'(vs1); in_vs2 = 5'(vs2);
    in_wr_vd = wr; in_rd_vs1 = r1; in_rd_vs2 = r2; in_lmul = 3'(lmul);
    flush = fl; unit_done = done;
    #1;
    nonEmpty = modelQ.size() > 0;
    hz = 0; hBusy = 0;
    if (nonEmpty) begin
      h = modelQ[0];
      hz = (h.r1 && groupPending(h.vs1, h.span)) || (h.r2 && groupPending(h.vs2, h.span)) ||
           (h.wr && groupPending(h.vd, h.span));
      hBusy = busy[h.unit];
    end
    doIssue = nonEmpty && !hz && !hBusy && !fl;
    expBusy = 0;
    for (int u = 0; u < NUM_UNITS; u++) expBusy[u] = busy[u];
    checkOutput("in_ready", in_ready, modelQ.size() < QDEPTH);
    checkOutput("q_count", q_count, modelQ.size());
    checkOutput("iss_valid", iss_valid, doIssue ? (64'd1 << h.unit) : 0);
    checkOutput("stall_hazard", stall_hazard, nonEmpty && hz);
    checkOutput("stall_busy", stall_busy, nonEmpty && !hz && hBusy);
    checkOutput("unit_busy", unit_busy, expBusy);
    checkOutput("idle", idle, !nonEmpty && expBusy == 0);
    checkOutput("iss_instr", iss_instr, doIssue ? h.instr : heldInstr);
    checkOutput("iss_vd", iss_vd, doIssue ? h.vd : heldVd);
    checkOutput("iss_vs1", iss_vs1, doIssue ? h.vs1 : heldVs1);
    checkOutput("iss_vs2", iss_vs2, doIssue ? h.vs2 : heldVs2);

    // Advance the model to the state after the coming clock edge.
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (done[u] && busy[u]) begin
        busy[u] = 0;
        if (recWr[u]) for (int r = recBase[u]; r < recBase[u] + recSpan[u] && r < 32; r++) pend[r] = 0;
      end
    end
    if (doIssue) begin
      void'(modelQ.pop_front());
      busy[h.unit] = 1;
      recWr[h.unit] = h.wr; recBase[h.unit] = h.vd; recSpan[h.unit] = h.span;
      if (h.wr) for (int r = h.vd; r < h.vd + h.span && r < 32; r++) pend[r] = 1;
      heldInstr = h.instr; heldVd = h.vd; heldVs1 = h.vs1; heldVs2 = h.vs2;
    end
    if (fl) modelQ.delete();
    else if (v && nonEmpty + 0 >= 0 && modelQ.size() + (doIssue ? 1 : 0) < QDEPTH) begin
      e.instr = instr; e.unit = unit; e.vd = vd; e.vs1 = vs1; e.vs2 = vs2;
      e.wr = wr; e.r1 = r1; e.r2 = r2;
      e.span = (lmul < 4) ? (1 << lmul) : 1;
      modelQ.push_back(e);
    end
  endtask

  task automatic idleCycle(input logic [3:0] done);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, done);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_q_count"}, q_count, 0);
    checkOutput({tag, "_unit_busy"}, unit_busy, 0);
    checkOutput({tag, "_iss_valid"}, iss_valid, 0);
    checkOutput({tag, "_iss_instr"}, iss_instr, 0);
    checkOutput({tag, "_iss_vd"}, iss_vd, 0);
    checkOutput({tag, "_stalls"}, {stall_hazard, stall_busy}, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst = 0;

    // Four independent instructions to the four units.
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h100 + i, i, i + 1, 0, 0, 1, 0, 0, 0, 0, 4'h0);
    repeat (2) idleCycle(4'h0);
    idleCycle(4'hf);

    // Overfill unit 0 so the FIFO fills and back-pressures.
    for (int i = 0; i < QDEPTH + 2; i++) applyStimulus(1, 32'h200 + i, 0, 5, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < QDEPTH + 1; i++) begin
      idleCycle(4'h1);
      idleCycle(4'h0);
    end

    // Read-after-write on a grouped destination, then a group clipped at v31.
    applyStimulus(1, 32'h300, 0, 8, 0, 0, 1, 0, 0, 2, 0, 4'h0);
    applyStimulus(1, 32'h301, 1, 0, 0, 10, 0, 0, 1, 0, 0, 4'h0);
    repeat (3) idleCycle(4'h0);
    idleCycle(4'h1);
    repeat (2) idleCycle(4'h0);
    applyStimulus(1, 32'h302, 2, 30, 0, 0, 1, 0, 0, 3, 0, 4'h0);
    applyStimulus(1, 32'h303, 3, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0);
    idleCycle(4'h0);

    // Flush behind a busy unit 2; in-flight work still retires.
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h400 + i, 2, 20, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    applyStimulus(1, 32'h4ff, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'h0);
    idleCycle(4'h0);
    idleCycle(4'hf);
    idleCycle(4'h0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom % 4) != 0, $urandom, $urandom % 4, $urandom % 32, $urandom % 32,
                    $urandom % 32, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 8,
                    ($urandom % 40) == 0, 4'($urandom & $urandom));
    end

    // Asynchronous reset in the middle of a cycle with work in flight.
    idleCycle(4'hf);
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h500 + i, i % 2, 12 + i, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    @(negedge clk);
    in_valid = 0; flush = 0; unit_done = 0;
    #2 rst = 1;
    #1 checkResetValues("async_rst");
    modelReset();
    @(negedge clk);
    rst = 0;
    idleCycle(4'hf);
    idleCycle(4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
